// File: rtl/egg_timer_countdown.sv
`default_nettype none
// ============================================================================
// Module   : egg_timer_countdown
// Purpose  : BCD MM:SS countdown core of the egg timer. Holds four BCD
//            digits, counts down once per 1 Hz strobe while running and
//            raises an alarm at 00:00 for ALARM_SECS strobes.
// Ports    : clk        - system clock
//            reset_n    - asynchronous active-low reset
//            pulse_1Hz  - one-cycle 1 Hz enable strobe
//            btn_start  - start/resume strobe
//            btn_stop   - pause strobe
//            btn_clear  - abort / reload preset strobe
//            inc_sec    - add one second (IDLE only)
//            inc_min    - add one minute (IDLE only)
//            sec_digit1/sec_digit2/min_digit1/min_digit2 - BCD time digits
//            running    - high while counting down
//            alarm      - high while the alarm is sounding
// Revision : 1.0 - initial release
// ============================================================================
module egg_timer_countdown #(
  parameter int DEFAULT_MIN = 3,
  parameter int DEFAULT_SEC = 0,
  parameter int ALARM_SECS  = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pulse_1Hz,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_clear,
  input  logic       inc_sec,
  input  logic       inc_min,
  output logic [3:0] sec_digit1,
  output logic [3:0] sec_digit2,
  output logic [3:0] min_digit1,
  output logic [3:0] min_digit2,
  output logic       running,
  output logic       alarm
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] c_MIN_TENS = 4'(DEFAULT_MIN / 10);
  localparam logic [3:0] c_MIN_ONES = 4'(DEFAULT_MIN % 10);
  localparam logic [3:0] c_SEC_TENS = 4'(DEFAULT_SEC / 10);
  localparam logic [3:0] c_SEC_ONES = 4'(DEFAULT_SEC % 10);
  localparam logic [7:0] c_ALARM    = 8'(ALARM_SECS);

  state_t     r_state, w_state;
  logic [3:0] r_m2, r_m1, r_s2, r_s1;
  logic [3:0] w_m2, w_m1, w_s2, w_s1;
  logic [7:0] r_acnt, w_acnt;
  logic       r_running, r_alarm;
  logic       w_preset;
  logic       w_is_zero;
  logic [3:0] w_dec_m2, w_dec_m1, w_dec_s2, w_dec_s1;
  logic       w_dec_zero;

  // One-second BCD decrement, borrowing from the least significant digit up.
  always_comb begin
    w_dec_m2 = r_m2;
    w_dec_m1 = r_m1;
    w_dec_s2 = r_s2;
    w_dec_s1 = r_s1;
    if (r_s1 != 4'd0) begin
      w_dec_s1 = r_s1 - 4'd1;
    end else begin
      w_dec_s1 = 4'd9;
      if (r_s2 != 4'd0) begin
        w_dec_s2 = r_s2 - 4'd1;
      end else begin
        w_dec_s2 = 4'd5;
        if (r_m1 != 4'd0) begin
          w_dec_m1 = r_m1 - 4'd1;
        end else begin
          w_dec_m1 = 4'd9;
          w_dec_m2 = r_m2 - 4'd1;
        end
      end
    end
  end

  assign w_is_zero  = (r_m2 == 4'd0) && (r_m1 == 4'd0) && (r_s2 == 4'd0) && (r_s1 == 4'd0);
  assign w_dec_zero = (w_dec_m2 == 4'd0) && (w_dec_m1 == 4'd0) &&
                      (w_dec_s2 == 4'd0) && (w_dec_s1 == 4'd0);

  // Next-state / next-digit logic. Buttons are examined in priority order
  // clear > stop > start > inc_min > inc_sec, so a higher button that is
  // ignored in a state still masks the lower ones.
  always_comb begin
    w_state  = r_state;
    w_m2     = r_m2;
    w_m1     = r_m1;
    w_s2     = r_s2;
    w_s1     = r_s1;
    w_acnt   = r_acnt;
    w_preset = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (btn_clear) begin
          w_preset = 1'b1;
        end else if (btn_stop) begin
          w_state = ST_IDLE;
        end else if (btn_start) begin
          if (!w_is_zero) w_state = ST_RUN;
        end else if (inc_min) begin
          if (r_m1 == 4'd9) begin
            w_m1 = 4'd0;
            w_m2 = (r_m2 == 4'd9) ? 4'd0 : r_m2 + 4'd1;
          end else begin
            w_m1 = r_m1 + 4'd1;
          end
        end else if (inc_sec) begin
          // Seconds wrap 59 -> 00 without touching the minutes.
          if (r_s1 == 4'd9) begin
            w_s1 = 4'd0;
            w_s2 = (r_s2 == 4'd5) ? 4'd0 : r_s2 + 4'd1;
          end else begin
            w_s1 = r_s1 + 4'd1;
          end
        end
      end

      ST_RUN: begin
        if (btn_clear) begin
          w_preset = 1'b1;
        end else if (pulse_1Hz) begin
          w_m2 = w_dec_m2;
          w_m1 = w_dec_m1;
          w_s2 = w_dec_s2;
          w_s1 = w_dec_s1;
          // Reaching 00:00 wins over a simultaneous stop.
          if (w_dec_zero) begin
            w_state = ST_DONE;
            w_acnt  = 8'd0;
          end else if (btn_stop) begin
            w_state = ST_PAUSE;
          end
        end else if (btn_stop) begin
          w_state = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        if (btn_clear) begin
          w_preset = 1'b1;
        end else if (btn_stop) begin
          w_state = ST_PAUSE;
        end else if (btn_start) begin
          w_state = ST_RUN;
        end
      end

      ST_DONE: begin
        if (btn_clear || btn_stop || btn_start) begin
          w_preset = 1'b1;
        end else if (pulse_1Hz) begin
          if (8'(r_acnt + 8'd1) == c_ALARM) begin
            w_preset = 1'b1;
          end else begin
            w_acnt = r_acnt + 8'd1;
          end
        end
      end

      default: begin
        w_preset = 1'b1;
      end
    endcase

    if (w_preset) begin
      w_state = ST_IDLE;
      w_m2    = c_MIN_TENS;
      w_m1    = c_MIN_ONES;
      w_s2    = c_SEC_TENS;
      w_s1    = c_SEC_ONES;
      w_acnt  = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_m2      <= c_MIN_TENS;
      r_m1      <= c_MIN_ONES;
      r_s2      <= c_SEC_TENS;
      r_s1      <= c_SEC_ONES;
      r_acnt    <= 8'd0;
      r_running <= 1'b0;
      r_alarm   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_m2      <= w_m2;
      r_m1      <= w_m1;
      r_s2      <= w_s2;
      r_s1      <= w_s1;
      r_acnt    <= w_acnt;
      r_running <= (w_state == ST_RUN);
      r_alarm   <= (w_state == ST_DONE);
    end
  end

  assign min_digit2 = r_m2;
  assign min_digit1 = r_m1;
  assign sec_digit2 = r_s2;
  assign sec_digit1 = r_s1;
  assign running    = r_running;
  assign alarm      = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_egg_timer_countdown.sv
`default_nettype none
// ============================================================================
// Module   : tb_egg_timer_countdown
// Purpose  : Self-checking bench for egg_timer_countdown. A time-in-seconds
//            reference model is compared against the DUT on every falling
//            edge; directed sequences add literal expectations, followed by
//            randomized strobes and occasional asynchronous resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_egg_timer_countdown;

  localparam int ALARM_SECS = 10;

  // Strobe bit positions for cyc()
  localparam logic [5:0] P  = 6'b100000;  // pulse_1Hz
  localparam logic [5:0] ST = 6'b010000;  // btn_start
  localparam logic [5:0] SP = 6'b001000;  // btn_stop
  localparam logic [5:0] CL = 6'b000100;  // btn_clear
  localparam logic [5:0] IM = 6'b000010;  // inc_min
  localparam logic [5:0] IS = 6'b000001;  // inc_sec

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pulse_1Hz = 1'b0, btn_start = 1'b0, btn_stop = 1'b0;
  logic       btn_clear = 1'b0, inc_sec = 1'b0, inc_min = 1'b0;
  logic [3:0] sec_digit1, sec_digit2, min_digit1, min_digit2;
  logic       running, alarm;

  int checks = 0;
  int errors = 0;

  egg_timer_countdown #(
    .DEFAULT_MIN(3),
    .DEFAULT_SEC(0),
    .ALARM_SECS (ALARM_SECS)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pulse_1Hz (pulse_1Hz),
    .btn_start (btn_start),
    .btn_stop  (btn_stop),
    .btn_clear (btn_clear),
    .inc_sec   (inc_sec),
    .inc_min   (inc_min),
    .sec_digit1(sec_digit1),
    .sec_digit2(sec_digit2),
    .min_digit1(min_digit1),
    .min_digit2(min_digit2),
    .running   (running),
    .alarm     (alarm)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: minutes and seconds as plain integers.
  // --------------------------------------------------------------------------
  int m_state = M_IDLE;
  int m_mm = 3, m_ss = 0, m_cnt = 0;

  always @(posedge clk or negedge reset_n) begin : model
    int st, mm, ss, cnt, tot;
    if (!reset_n) begin
      m_state <= M_IDLE;
      m_mm    <= 3;
      m_ss    <= 0;
      m_cnt   <= 0;
    end else begin
      st = m_state; mm = m_mm; ss = m_ss; cnt = m_cnt;
      if (btn_clear) begin
        st = M_IDLE; mm = 3; ss = 0; cnt = 0;
      end else begin
        case (m_state)
          M_IDLE: begin
            if (btn_stop) begin
              st = M_IDLE;
            end else if (btn_start) begin
              if (mm != 0 || ss != 0) st = M_RUN;
            end else if (inc_min) begin
              mm = (mm + 1) % 100;
            end else if (inc_sec) begin
              ss = (ss + 1) % 60;
            end
          end
          M_RUN: begin
            if (pulse_1Hz) begin
              tot = mm * 60 + ss - 1;
              mm = tot / 60;
              ss = tot % 60;
              if (tot == 0) begin
                st = M_DONE; cnt = 0;
              end else if (btn_stop) begin
                st = M_PAUSE;
              end
            end else if (btn_stop) begin
              st = M_PAUSE;
            end
          end
          M_PAUSE: begin
            if (!btn_stop && btn_start) st = M_RUN;
          end
          default: begin
            if (btn_stop || btn_start) begin
              st = M_IDLE; mm = 3; ss = 0; cnt = 0;
            end else if (pulse_1Hz) begin
              cnt = cnt + 1;
              if (cnt == ALARM_SECS) begin
                st = M_IDLE; mm = 3; ss = 0; cnt = 0;
              end
            end
          end
        endcase
      end
      m_state <= st;
      m_mm    <= mm;
      m_ss    <= ss;
      m_cnt   <= cnt;
    end
  end

  function automatic logic [15:0] exp_digits(input int mm, input int ss);
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  wire [15:0] w_dut_digits = {min_digit2, min_digit1, sec_digit2, sec_digit1};

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [17:0] exp_v, got_v;
    exp_v = {exp_digits(m_mm, m_ss), m_state == M_RUN, m_state == M_DONE};
    got_v = {w_dut_digits, running, alarm};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL model_cmp t=%0t got digits=%h run=%b alm=%b required digits=%h run=%b alm=%b",
               $time, got_v[17:2], got_v[1], got_v[0], exp_v[17:2], exp_v[1], exp_v[0]);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers. Callers sit at posedge+1.
  // --------------------------------------------------------------------------
  task automatic cyc(input logic [5:0] v);
    {pulse_1Hz, btn_start, btn_stop, btn_clear, inc_min, inc_sec} = v;
    @(posedge clk);
    #1;
    {pulse_1Hz, btn_start, btn_stop, btn_clear, inc_min, inc_sec} = 6'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, expv);
    end
  endtask

  // Reach mm:ss from IDLE preset 03:00 using only the increment buttons.
  task automatic load(input int mm, input int ss);
    cyc(CL);
    repeat ((mm + 97) % 100) cyc(IM);
    repeat (ss) cyc(IS);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_digits", 32'(w_dut_digits), 32'h0300);
    chk("reset_flags", {30'd0, running, alarm}, 32'd0);
    reset_n = 1'b1;
    cyc(6'b0);
    chk("idle_digits", 32'(w_dut_digits), 32'h0300);

    // Start and first decrement
    cyc(ST);
    chk("start_running", {31'd0, running}, 32'd1);
    cyc(P);
    chk("first_dec", 32'(w_dut_digits), 32'h0259);

    // Increment wraps and start at 00:00
    load(0, 59);
    chk("load_0059", 32'(w_dut_digits), 32'h0059);
    cyc(IS);
    chk("sec_wrap", 32'(w_dut_digits), 32'h0000);
    load(99, 0);
    chk("load_9900", 32'(w_dut_digits), 32'h9900);
    cyc(IM);
    chk("min_wrap", 32'(w_dut_digits), 32'h0000);
    cyc(ST);
    chk("start_zero_run", {31'd0, running}, 32'd0);
    chk("start_zero_digits", 32'(w_dut_digits), 32'h0000);

    // Borrow across minutes and reaching 00:00
    load(10, 0);
    cyc(ST);
    cyc(P);
    chk("borrow_1000", 32'(w_dut_digits), 32'h0959);
    load(0, 2);
    cyc(ST);
    cyc(P);
    chk("dec_0001", 32'(w_dut_digits), 32'h0001);
    cyc(P);
    chk("done_flags", {30'd0, running, alarm}, 32'd1);
    chk("done_digits", 32'(w_dut_digits), 32'h0000);

    // Alarm duration
    repeat (ALARM_SECS - 1) cyc(P);
    chk("alarm_hold", {31'd0, alarm}, 32'd1);
    cyc(P);
    chk("alarm_expire", {30'd0, running, alarm}, 32'd0);
    chk("alarm_preset", 32'(w_dut_digits), 32'h0300);

    // Early exit with stop, then a full alarm to confirm the counter restarted
    load(0, 1);
    cyc(ST);
    cyc(P);
    repeat (3) cyc(P);
    cyc(SP);
    chk("stop_exit", {30'd0, running, alarm}, 32'd0);
    chk("stop_exit_digits", 32'(w_dut_digits), 32'h0300);
    load(0, 1);
    cyc(ST);
    cyc(P);
    repeat (ALARM_SECS - 1) cyc(P);
    chk("alarm_hold2", {31'd0, alarm}, 32'd1);
    cyc(P);
    chk("alarm_expire2", {31'd0, alarm}, 32'd0);

    // Stop together with pulse, pause freezes, clear beats pulse
    load(1, 30);
    cyc(ST);
    cyc(SP | P);
    chk("stop_pulse_digits", 32'(w_dut_digits), 32'h0129);
    chk("stop_pulse_run", {31'd0, running}, 32'd0);
    repeat (5) cyc(P);
    chk("pause_frozen", 32'(w_dut_digits), 32'h0129);
    cyc(ST);
    chk("resume", {31'd0, running}, 32'd1);
    cyc(CL | P);
    chk("clear_pulse", 32'(w_dut_digits), 32'h0300);
    chk("clear_pulse_run", {31'd0, running}, 32'd0);

    // Asynchronous reset in the middle of a cycle while running
    load(0, 46);
    cyc(ST);
    cyc(P);
    chk("pre_reset", 32'(w_dut_digits), 32'h0045);
    #1 reset_n = 1'b0;
    #1;
    chk("async_reset_digits", 32'(w_dut_digits), 32'h0300);
    chk("async_reset_run", {31'd0, running}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc(P);
    chk("post_reset_pulse", {w_dut_digits, 15'd0, running}, {16'h0300, 16'd0});

    // Randomized phase
    for (int i = 0; i < 6000; i++) begin
      logic [5:0] v;
      v[5] = ($urandom_range(0, 99) < 35);
      v[4] = ($urandom_range(0, 99) < 8);
      v[3] = ($urandom_range(0, 99) < 5);
      v[2] = ($urandom_range(0, 99) < 2);
      v[1] = ($urandom_range(0, 99) < 6);
      v[0] = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 999) < 2) begin
        #1 reset_n = 1'b0;
        cyc(6'b0);
        reset_n = 1'b1;
      end else begin
        cyc(v);
      end
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
